// File: rtl/spw_pkg.sv
// Shared definitions for the SpaceWire transmit path: character codes,
// transmitter states and small character-building helpers.
package spw_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_e;

  // Control-character codes as {c1, c0}; c0 goes on the wire first.
  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_EOP = 2'b01;
  localparam logic [1:0] CODE_EEP = 2'b10;
  localparam logic [1:0] CODE_ESC = 2'b11;

  localparam int MAX_CREDIT_DEFAULT = 56;
  localparam int CHAR_W             = 14;  // longest unit: ESC + data (time code)

  // hist is the XOR of the previous character's payload bits.
  function automatic logic [3:0] ctrl_char(input logic [1:0] code, input logic hist);
    return {code, 1'b1, hist};
  endfunction

  function automatic logic [9:0] data_char(input logic [7:0] d, input logic hist);
    return {d, 1'b0, ~hist};
  endfunction

endpackage

// File: rtl/spw_ds_encoder.sv
// Bit-period divider and Data-Strobe line registers; requests a new bit
// every CLK_DIV cycles while shifting is enabled.
module spw_ds_encoder
  import spw_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic pclk,
  input  logic resetn,
  input  logic i_bit,
  input  logic i_bit_strobe,
  input  logic i_clear,
  output logic o_load,
  output logic o_dout,
  output logic o_sout
);

  logic [7:0] r_cnt;
  logic       r_dout;
  logic       r_sout;

  assign o_load = i_bit_strobe && (r_cnt == 8'd0);
  assign o_dout = r_dout;
  assign o_sout = r_sout;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_sout <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_sout <= 1'b0;
    end else begin
      if (!i_bit_strobe || r_cnt == 8'(CLK_DIV - 1))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 8'd1;
      // Strobe toggles exactly when data does not.
      if (o_load) begin
        r_dout <= i_bit;
        r_sout <= r_sout ^ ~(i_bit ^ r_dout);
      end
    end
  end

endmodule

// File: rtl/spw_tx_encoder.sv
// SpaceWire link transmitter: character selection, parity, credit and
// pending-FCT bookkeeping feeding the DS line encoder.
module spw_tx_encoder
  import spw_pkg::*;
#(
  parameter int CLK_DIV    = 1,
  parameter int MAX_CREDIT = MAX_CREDIT_DEFAULT
) (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       enable_tx,
  input  logic       send_null_tx,
  input  logic       send_fct_tx,
  input  logic       gotfct_rx,
  input  logic       fct_req,
  input  logic       tx_valid,
  input  logic [8:0] tx_data,
  output logic       tx_ready,
  input  logic       tc_valid,
  input  logic [7:0] tc_data,
  output logic       tc_ready,
  output logic       dout,
  output logic       sout,
  output logic [5:0] credit,
  output logic       credit_error
);

  tx_state_e         r_state;
  logic [CHAR_W-1:0] r_shreg;
  logic [3:0]        r_len;
  logic              r_par;
  logic [5:0]        r_credit;
  logic [2:0]        r_pending;
  logic              r_credit_error;

  logic              w_load;
  logic              w_select;
  logic              w_sel_tc;
  logic              w_sel_fct;
  logic              w_sel_data;
  logic              w_take_fct;
  logic              w_over;
  logic [1:0]        w_eop_code;
  logic [CHAR_W-1:0] w_next_char;
  logic [3:0]        w_next_len;
  logic              w_next_par;
  logic [5:0]        w_credit_n;

  // A new character is chosen when leaving IDLE or while its predecessor's last bit goes out.
  assign w_select   = enable_tx && send_null_tx &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_SHIFT) && w_load && (r_len == 4'd1)));
  assign w_sel_tc   = send_fct_tx && tc_valid;
  assign w_sel_fct  = send_fct_tx && (r_pending != 3'd0) && !w_sel_tc;
  assign w_sel_data = send_fct_tx && tx_valid && (r_credit != 6'd0) && !w_sel_tc && !w_sel_fct;
  assign w_take_fct = w_select && w_sel_fct;
  assign tx_ready   = w_select && w_sel_data;
  assign tc_ready   = w_select && w_sel_tc;
  assign w_eop_code = tx_data[0] ? CODE_EEP : CODE_EOP;
  assign w_over     = gotfct_rx && (({1'b0, r_credit} + 7'd8) > 7'(MAX_CREDIT));

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_next_char = '0;
    w_next_len  = 4'd8;
    w_next_par  = 1'b0;
    if (w_sel_tc) begin
      // The ESC payload has even parity, so the data half sees history 0.
      w_next_char = {data_char(tc_data, 1'b0), ctrl_char(CODE_ESC, r_par)};
      w_next_len  = 4'd14;
      w_next_par  = ^tc_data;
    end else if (w_sel_fct) begin
      w_next_char = {10'd0, ctrl_char(CODE_FCT, r_par)};
      w_next_len  = 4'd4;
    end else if (w_sel_data && tx_data[8]) begin
      w_next_char = {10'd0, ctrl_char(w_eop_code, r_par)};
      w_next_len  = 4'd4;
      w_next_par  = ^w_eop_code;
    end else if (w_sel_data) begin
      w_next_char = {4'd0, data_char(tx_data[7:0], r_par)};
      w_next_len  = 4'd10;
      w_next_par  = ^tx_data[7:0];
    end else begin
      w_next_char = {6'd0, ctrl_char(CODE_FCT, 1'b0), ctrl_char(CODE_ESC, r_par)};
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_OFF;
      r_shreg <= '0;
      r_len   <= '0;
      r_par   <= 1'b0;
    end else if (!enable_tx) begin
      r_state <= ST_OFF;
      r_shreg <= '0;
      r_len   <= '0;
      r_par   <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_select) begin
            r_state <= ST_SHIFT;
            r_shreg <= w_next_char;
            r_len   <= w_next_len;
            r_par   <= w_next_par;
          end
        end
        ST_SHIFT: begin
          if (w_load) begin
            if (r_len == 4'd1) begin
              if (w_select) begin
                r_shreg <= w_next_char;
                r_len   <= w_next_len;
                r_par   <= w_next_par;
              end else begin
                r_state <= ST_IDLE;
                r_len   <= '0;
              end
            end else begin
              r_shreg <= r_shreg >> 1;
              r_len   <= r_len - 4'd1;
            end
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  always_comb begin
    w_credit_n = r_credit;
    if (gotfct_rx && !w_over) w_credit_n = w_credit_n + 6'd8;
    if (tx_ready)             w_credit_n = w_credit_n - 6'd1;
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_credit       <= '0;
      r_credit_error <= 1'b0;
      r_pending      <= '0;
    end else if (!enable_tx) begin
      r_credit       <= '0;
      r_credit_error <= 1'b0;
      r_pending      <= '0;
    end else begin
      r_credit       <= w_credit_n;
      r_credit_error <= w_over;
      if (fct_req && !w_take_fct && r_pending != 3'd7)
        r_pending <= r_pending + 3'd1;
      else if (w_take_fct && !fct_req)
        r_pending <= r_pending - 3'd1;
    end
  end

  assign credit       = r_credit;
  assign credit_error = r_credit_error;

  spw_ds_encoder #(.CLK_DIV(CLK_DIV)) u_ds (
    .pclk        (pclk),
    .resetn      (resetn),
    .i_bit       (r_shreg[0]),
    .i_bit_strobe(r_state == ST_SHIFT),
    .i_clear     (!enable_tx),
    .o_load      (w_load),
    .o_dout      (dout),
    .o_sout      (sout)
  );

endmodule

// File: tb/tb_spw_tx_encoder.sv
// Directed/randomised bench: decodes the DS pair back into characters and
// compares them with the expected character stream and credit arithmetic.
module tb_spw_tx_encoder;

  localparam int CLK_DIV    = 2;
  localparam int MAX_CREDIT = 56;

  typedef enum int {T_NULL, T_FCT, T_DATA, T_EOP, T_EEP, T_TC, T_BAD} tok_e;
  typedef struct {
    tok_e       kind;
    logic [7:0] val;
  } tok_t;

  logic       pclk = 1'b0;
  logic       resetn, enable_tx, send_null_tx, send_fct_tx, gotfct_rx, fct_req;
  logic       tx_valid, tc_valid, tx_ready, tc_ready, dout, sout, credit_error;
  logic [8:0] tx_data;
  logic [7:0] tc_data;
  logic [5:0] credit;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_credit = 0;
  bit   mon_en   = 1'b0;
  bit   raw_log[$];
  bit   cur_bits[$];
  tok_t tok_q[$];
  tok_t exp_q[$];
  logic [1:0] mon_prev = 2'b00;
  int   par_hist = 0;
  bit   esc_pend = 1'b0;
  int   cyc_cnt  = 0;
  int   last_evt = -1;

  spw_tx_encoder #(.CLK_DIV(CLK_DIV), .MAX_CREDIT(MAX_CREDIT)) dut (
    .pclk(pclk), .resetn(resetn), .enable_tx(enable_tx), .send_null_tx(send_null_tx),
    .send_fct_tx(send_fct_tx), .gotfct_rx(gotfct_rx), .fct_req(fct_req),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tc_valid(tc_valid), .tc_data(tc_data), .tc_ready(tc_ready),
    .dout(dout), .sout(sout), .credit(credit), .credit_error(credit_error)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tok(input tok_e k, input logic [7:0] v);
    tok_t t;
    t.kind = k;
    t.val  = v;
    tok_q.push_back(t);
  endtask

  // Reassemble line bits into characters, check parity, pair ESC halves.
  task automatic parse_char();
    int need, ones;
    logic [7:0] v;
    logic [1:0] code;
    if (cur_bits.size() < 2) return;
    need = cur_bits[1] ? 4 : 10;
    if (cur_bits.size() != need) return;
    check("char_parity", 32'((par_hist + int'(cur_bits[0]) + int'(cur_bits[1])) % 2), 32'd1);
    ones = 0;
    for (int i = 2; i < need; i++) ones += int'(cur_bits[i]);
    par_hist = ones % 2;
    if (!cur_bits[1]) begin
      for (int i = 0; i < 8; i++) v[i] = cur_bits[i + 2];
      if (esc_pend) push_tok(T_TC, v); else push_tok(T_DATA, v);
      esc_pend = 1'b0;
    end else begin
      code = {cur_bits[3], cur_bits[2]};
      if (code == 2'b11) begin
        if (esc_pend) push_tok(T_BAD, 8'h0);
        esc_pend = ~esc_pend;
      end else if (esc_pend) begin
        push_tok(code == 2'b00 ? T_NULL : T_BAD, 8'h0);
        esc_pend = 1'b0;
      end else begin
        push_tok(code == 2'b00 ? T_FCT : (code == 2'b01 ? T_EOP : T_EEP), 8'h0);
      end
    end
    cur_bits.delete();
  endtask

  always @(negedge pclk) begin
    #2;
    cyc_cnt++;
    if (!mon_en) begin
      mon_prev = {dout, sout};
      cur_bits.delete();
      par_hist = 0;
      esc_pend = 1'b0;
      last_evt = -1;
    end else if ({dout, sout} != mon_prev) begin
      check("ds_one_line_toggles",
            32'(int'(dout != mon_prev[1]) + int'(sout != mon_prev[0])), 32'd1);
      if (last_evt >= 0) check("bit_period", 32'(cyc_cnt - last_evt), 32'(CLK_DIV));
      last_evt = cyc_cnt;
      mon_prev = {dout, sout};
      raw_log.push_back(dout);
      cur_bits.push_back(dout);
      parse_char();
    end
  end

  task automatic expect_tok(input string tag, input tok_e k, input logic [7:0] v);
    tok_t t;
    bit got = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      while (tok_q.size() > 0 && !got) begin
        t = tok_q.pop_front();
        if (t.kind != T_NULL) got = 1'b1;
      end
      if (!got) @(negedge pclk);
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_kind"}, 32'(t.kind), 32'(k));
      check({tag, "_val"}, 32'(t.val), 32'(v));
    end
  endtask

  task automatic expect_nulls(input string tag, input int n);
    tok_t t;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 200 && tok_q.size() == 0; c++) @(negedge pclk);
      check({tag, "_seen"}, 32'(tok_q.size() > 0), 32'd1);
      if (tok_q.size() > 0) begin
        t = tok_q.pop_front();
        check({tag, "_is_null"}, 32'(t.kind), 32'(T_NULL));
      end
    end
  endtask

  task automatic verify_expected(input string tag);
    tok_t t;
    while (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      expect_tok(tag, t.kind, t.val);
    end
  endtask

  task automatic send_nchar(input logic [8:0] d, input bit simul);
    bit   got = 1'b0;
    tok_t t;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      #1;
      if (tx_ready) got = 1'b1; else @(negedge pclk);
    end
    check("tx_ready_seen", 32'(got), 32'd1);
    if (got) begin
      if (simul) gotfct_rx = 1'b1;
      @(negedge pclk);
      gotfct_rx = 1'b0;
      #1;
      m_credit = m_credit + (simul ? 7 : -1);
      check("tx_ready_one_cycle", 32'(tx_ready), 32'd0);
      check("credit_after_nchar", 32'(credit), 32'(m_credit));
      t.val  = d[8] ? 8'h0 : d[7:0];
      t.kind = !d[8] ? T_DATA : (d[0] ? T_EEP : T_EOP);
      exp_q.push_back(t);
    end
    tx_valid = 1'b0;
  endtask

  task automatic pulse_gotfct(input bit exp_err);
    gotfct_rx = 1'b1;
    @(negedge pclk);
    gotfct_rx = 1'b0;
    #1;
    if (!exp_err) m_credit += 8;
    check("credit_after_gotfct", 32'(credit), 32'(m_credit));
    check("credit_error_flag", 32'(credit_error), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_idx, seen, bad;
    bit tc_done;
    logic [7:0] pat;
    logic [8:0] d;
    int r;

    resetn = 1'b0; enable_tx = 1'b0; send_null_tx = 1'b0; send_fct_tx = 1'b0;
    gotfct_rx = 1'b0; fct_req = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tc_valid = 1'b0; tc_data = '0;
    repeat (3) @(negedge pclk);
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_tc_ready", 32'(tc_ready), 32'd0);
    check("rst_credit_error", 32'(credit_error), 32'd0);
    @(negedge pclk);
    resetn = 1'b1;
    @(negedge pclk);

    // NULL stream after enabling
    enable_tx = 1'b1; send_null_tx = 1'b1; mon_en = 1'b1;
    @(negedge pclk); #1 check("t1_sout_off_idle", 32'(sout), 32'd0);
    @(negedge pclk); #1 check("t1_sout_enter_shift", 32'(sout), 32'd0);
    @(negedge pclk); #1;
    check("t1_first_bit_dout", 32'(dout), 32'd0);
    check("t1_first_bit_sout", 32'(sout), 32'd1);
    for (int c = 0; c < 200 && raw_log.size() < 16; c++) @(negedge pclk);
    check("t1_bits_seen", 32'(raw_log.size() >= 16), 32'd1);
    pat = 8'b0010_1110;
    if (raw_log.size() >= 16)
      for (int i = 0; i < 16; i++) check("t1_null_bit", 32'(raw_log[i]), 32'(pat[i % 8]));

    // Credit grant and eight N-chars
    pulse_gotfct(1'b0);
    send_fct_tx = 1'b1;
    send_nchar(9'h055, 1'b0);
    for (int i = 0; i < 7; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      d = 9'h100;
      else if (r == 1) d = 9'h101;
      else             d = {1'b0, 8'($urandom)};
      send_nchar(d, 1'b0);
    end
    verify_expected("t2_nchar");

    // Time code beats three queued FCTs
    tc_valid = 1'b1; tc_data = 8'hA5; tc_done = 1'b0;
    for (int c = 0; c < 100 && !(tc_done && c >= 3); c++) begin
      fct_req = (c < 3);
      #1;
      if (tc_ready && tc_valid) tc_done = 1'b1;
      @(negedge pclk);
      if (tc_done) tc_valid = 1'b0;
    end
    fct_req = 1'b0; tc_valid = 1'b0;
    check("t3_tc_ready_seen", 32'(tc_done), 32'd1);
    expect_tok("t3_tc", T_TC, 8'hA5);
    for (int i = 0; i < 3; i++) expect_tok("t3_fct", T_FCT, 8'h0);
    expect_nulls("t3_after", 2);

    // Zero credit blocks N-chars; then simultaneous grant and selection
    tok_q.delete();
    tx_data = {1'b0, 8'($urandom)}; tx_valid = 1'b1; seen = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (tx_ready) seen++;
      @(negedge pclk);
    end
    tx_valid = 1'b0;
    check("t5_no_ready_at_zero", 32'(seen), 32'd0);
    bad = 0;
    foreach (tok_q[i]) if (tok_q[i].kind != T_NULL) bad++;
    check("t5_only_nulls", 32'(bad), 32'd0);
    check("t5_some_chars", 32'(tok_q.size() > 0), 32'd1);
    pulse_gotfct(1'b0);
    send_nchar({1'b0, 8'($urandom)}, 1'b0);
    send_nchar({1'b0, 8'($urandom)}, 1'b1);
    verify_expected("t5_nchar");

    // Disable mid data character
    send_nchar({1'b0, 8'($urandom)}, 1'b0);
    exp_q.delete();
    fct_req = 1'b1;
    @(negedge pclk);
    fct_req = 1'b0;
    @(negedge pclk);
    enable_tx = 1'b0; mon_en = 1'b0;
    @(negedge pclk); #1;
    check("t6_dout_cleared", 32'(dout), 32'd0);
    check("t6_sout_cleared", 32'(sout), 32'd0);
    check("t6_credit_cleared", 32'(credit), 32'd0);
    check("t6_tx_ready_low", 32'(tx_ready), 32'd0);
    tok_q.delete();
    m_credit = 0;
    @(negedge pclk);
    enable_tx = 1'b1; mon_en = 1'b1;
    first_idx = raw_log.size();
    for (int c = 0; c < 100 && raw_log.size() < first_idx + 4; c++) @(negedge pclk);
    check("t6_bits_seen", 32'(raw_log.size() >= first_idx + 4), 32'd1);
    if (raw_log.size() >= first_idx + 4) begin
      check("t6_esc_parity", 32'(raw_log[first_idx]), 32'd0);
      for (int i = 1; i < 4; i++) check("t6_esc_bit", 32'(raw_log[first_idx + i]), 32'd1);
    end
    expect_nulls("t6_no_stale_fct", 3);

    // Credit ceiling
    for (int i = 0; i < 7; i++) pulse_gotfct(1'b0);
    check("t4_credit_full", 32'(credit), 32'(MAX_CREDIT));
    pulse_gotfct(1'b1);
    @(negedge pclk); #1;
    check("t4_error_one_cycle", 32'(credit_error), 32'd0);
    check("t4_credit_kept", 32'(credit), 32'(MAX_CREDIT));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spw_tx_encoder.md
Name: spw_tx_encoder

Overview:
SpaceWire link transmitter (ECSS-E-ST-50-12C). Driven by the link state machine's enable_tx / send_null_tx / send_fct_tx controls.
Serialises NULL, FCT, N-chars (data, EOP, EEP) and time codes onto the Data-Strobe pair.
Maintains transmit credit from FCTs received by the receiver, and issues FCTs on local buffer-space requests.
Sits between the host TX FIFO / time-code source and the LVDS output pads.

Parameters:
CLK_DIV, 1, pclk cycles per transmitted bit (1..255)
MAX_CREDIT, 56, credit ceiling in N-chars (7 FCTs x 8)

Ports:
pclk  in  1  clock
resetn  in  1  async active-low reset
enable_tx  in  1  transmitter enabled (ready/started/connecting/run)
send_null_tx  in  1  NULL transmission permitted
send_fct_tx  in  1  FCT and N-char transmission permitted
gotfct_rx  in  1  one-cycle pulse: peer FCT received, +8 credit
fct_req  in  1  one-cycle pulse: local RX buffer freed 8 slots, queue one FCT
tx_valid  in  1  N-char available
tx_data  in  9  bit8=control flag; flag=0: [7:0] data; flag=1: [0]=0 EOP, [0]=1 EEP
tx_ready  out  1  one-cycle accept strobe for tx_data
tc_valid  in  1  time code pending
tc_data  in  8  time code value
tc_ready  out  1  one-cycle accept strobe for tc_data
dout  out  1  Data line
sout  out  1  Strobe line
credit  out  6  current transmit credit
credit_error  out  1  one-cycle pulse: credit overflow

Behaviour:
- Reset and enable_tx=0 (at any time, including mid-character):
  - dout=sout=0, tx_ready=tc_ready=credit_error=0.
  - credit=0, pending FCT count=0, parity history cleared (previous payload treated as zero ones).
  - FSM goes to OFF.
- FSM states: OFF -> IDLE -> SHIFT.
  - OFF: leaves when enable_tx=1.
  - IDLE: lines held at last value; move to SHIFT when send_null_tx=1.
  - SHIFT: returns to OFF only when enable_tx=0.
- Character formats, all sent LSB-first, parity bit first:
  - data: P,0,d0..d7 (10 bits)
  - FCT: P,1,0,0
  - EOP: P,1,1,0
  - EEP: P,1,0,1
  - ESC: P,1,1,1
  - NULL: ESC then FCT
  - time code: ESC then P,0,t0..t7
- Parity: P is chosen so that (payload bits of the previous character) + P + (current control flag) has an odd number of ones. Every character, including each half of NULL and time code, updates the parity history.
- Character selection happens at the last bit period of the current character. The next character's first bit follows with no gap. Priority:
  1. time code (tc_valid and send_fct_tx)
  2. FCT (pending>0 and send_fct_tx)
  3. N-char (tx_valid, credit>0, send_fct_tx)
  4. NULL
- tx_ready / tc_ready pulse in the selection cycle. The source advances on valid&ready.
- Credit rules:
  - gotfct_rx adds 8.
  - Selecting an N-char subtracts 1.
  - Both in the same cycle: net +7.
  - If the increment would exceed MAX_CREDIT: credit unchanged, credit_error=1 for one cycle.
  - Credit is never decremented below 0; N-chars are blocked at 0.
- Pending FCT counter (3 bits):
  - fct_req increments it, saturating at 7.
  - Selecting an FCT decrements it.
  - Simultaneous increment and decrement: unchanged.
- DS encoding:
  - Each bit holds for CLK_DIV pclk cycles.
  - On each bit boundary: dout<=bit; sout<=sout^~(bit^dout), so exactly one line toggles per bit.
  - Registered outputs, first bit appears 1 cycle after the FSM enters SHIFT.
- send_null_tx dropping to 0 while in SHIFT: the current character completes, then the FSM returns to IDLE.

Decomposition:
- Shared package spw_pkg: character code constants (FCT/EOP/EEP/ESC 2-bit codes), state encodings, MAX_CREDIT default.
- One sub-module spw_ds_encoder: bit-period divider plus DS line registers. Inputs: bit, bit_strobe, clear.

Test Plan:
1. Reset, enable_tx=1, send_null_tx=1, CLK_DIV=1 -> dout serial 0111 0100 repeating; sout after first bit = 1; no cycle with both dout and sout changing.
2. From NULL stream: gotfct_rx pulse, send_fct_tx=1, tx_valid with tx_data=0x055 -> credit 8 then 7; data character bits P,0,1,0,1,0,1,0,1,0 with odd parity over the window; tx_ready pulses once.
3. fct_req x3 plus tc_valid with tc_data=0xA5 in the same selection window -> time code (ESC, P,0,1,0,1,0,0,1,0,1) first, then 3 FCTs, then NULLs; pending reaches 0.
4. 7 gotfct_rx pulses -> credit=56; 8th pulse -> credit_error pulse, credit stays 56.
5. Credit=0 with tx_valid=1 -> only NULLs sent, tx_ready stays 0; gotfct_rx plus an N-char selection in the same cycle -> credit=7.
6. enable_tx deasserted mid data character -> next cycle dout=sout=0, credit=0, pending=0; re-enable -> first ESC parity=0.
